mem_port_arbiter: RTL

- Shares one single-port, variable-latency memory between the fetch stage (read-only) and the memory stage (load/store), sequencing each access and raising stalls toward the hazard unit.
- Sits between the fetch/memory stages and the data memory; the memory-stage request is MemToRegM | MemWriteM, the write flag is MemWriteM, and the address is ALUOutM.
- Data-port priority by default, with a starvation guard that forces fetch service.
- Watchdog on memory acknowledge; word-alignment check.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_watchdog.sv | 34 +++
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: one BUSY/RESP pair per requesting port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } arb_state_e;

  // Low address bits of a legal word access.
  localparam logic [1:0]  WORD_ALIGN_MASK  = 2'b00;

  // Read data substituted when an access times out.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // True when a byte address points at a word boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Acknowledge watchdog: counts cycles while an access is outstanding and
// flags the last permitted cycle so the arbiter can abort the access.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_r;

  // Cycle counter; saturates at TIMEOUT-1 so it can never wrap back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= '0;
    end else if (clear) begin
      wd_cnt_r <= '0;
    end else if (enable && (wd_cnt_r != CW'(TIMEOUT - 1))) begin
      wd_cnt_r <= wd_cnt_r + CW'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  assign timeout = enable && (wd_cnt_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch stage
// (read-only) and the memory stage (load/store). Data wins by default; a
// starvation counter forces a fetch grant after STARVE_MAX data grants made
// while fetch was waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          STARVE_MAX = 4,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_f,
  output logic        stall_m,
  output logic        align_err,
  output logic        bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_r;
  logic [SW-1:0] starve_cnt_r;
  logic          grant_d_s;
  logic          grant_i_s;
  logic          busy_s;
  logic          wd_timeout_s;

  assign busy_s = (state_r == BUSY_D) || (state_r == BUSY_I);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (~busy_s),
    .enable  (busy_s),
    .timeout (wd_timeout_s)
  );

  // Grant decision, only meaningful while the FSM is idle.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
      grant_d_s = dm_req && !(if_req && (starve_cnt_r == SW'(STARVE_MAX)));
      grant_i_s = !grant_d_s && if_req;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // Stalls are held low while reset is asserted so the pipeline sees a clean
  // release even if a requester keeps its request up through reset.
  assign stall_f = if_req & ~if_ready & ~reset;
  assign stall_m = dm_req & ~dm_ready & ~reset;

  // Arbiter FSM with registered memory strobes, ready pulses and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      if_rdata     <= 32'h0;
      dm_rdata     <= 32'h0;
      if_ready     <= 1'b0;
      dm_ready     <= 1'b0;
      align_err    <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          // Starvation bookkeeping: only data grants made over a waiting
          // fetch count; any other idle cycle resets the count.
          if (grant_d_s && if_req) begin
            if (starve_cnt_r == SW'(STARVE_MAX)) begin
              starve_cnt_r <= starve_cnt_r;
            end else begin
              starve_cnt_r <= starve_cnt_r + SW'(1);
            end
          end else begin
            starve_cnt_r <= '0;
          end

          if (grant_d_s) begin
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (is_word_aligned(dm_addr)) begin
              mem_en  <= 1'b1;
              mem_we  <= dm_we;
              state_r <= BUSY_D;
            end else begin
              mem_en    <= 1'b0;
              mem_we    <= 1'b0;
              dm_rdata  <= 32'h0;
              dm_ready  <= 1'b1;
              align_err <= 1'b1;
              state_r   <= RESP_D;
            end
          end else if (grant_i_s) begin
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
            mem_we    <= 1'b0;
            if (is_word_aligned(if_addr)) begin
              mem_en  <= 1'b1;
              state_r <= BUSY_I;
            end else begin
              mem_en    <= 1'b0;
              if_rdata  <= 32'h0;
              if_ready  <= 1'b1;
              align_err <= 1'b1;
              state_r   <= RESP_I;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        BUSY_D: begin
          if (mem_ack) begin
            // A store leaves the load-data register untouched.
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end else begin
              dm_rdata <= dm_rdata;
            end
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            dm_ready <= 1'b1;
            state_r  <= RESP_D;
          end else if (wd_timeout_s) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            dm_rdata <= ERR_DATA;
            dm_ready <= 1'b1;
            bus_err  <= 1'b1;
            state_r  <= RESP_D;
          end else begin
            state_r <= BUSY_D;
          end
        end

        BUSY_I: begin
          if (mem_ack) begin
            mem_en   <= 1'b0;
            if_rdata <= mem_rdata;
            if_ready <= 1'b1;
            state_r  <= RESP_I;
          end else if (wd_timeout_s) begin
            mem_en   <= 1'b0;
            if_rdata <= ERR_DATA;
            if_ready <= 1'b1;
            bus_err  <= 1'b1;
            state_r  <= RESP_I;
          end else begin
            state_r <= BUSY_I;
          end
        end

        RESP_D, RESP_I: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
